dequantize_elem: RTL and testbench
==================================

Name: dequantize_elem

Overview:
- Per-element dequantizer: converts one signed integer accumulator from the quantized GEMM array into an IEEE-754 single, multiplied by a positive FP scale supplied as separate mantissa and biased exponent fields.
- Instantiated LANES_NUM times inside the dequantize array, one instance per output lane.
- Fully pipelined: 2-cycle latency, one result per clock, no handshake.

Parameters:
- FP_DATA_W, 32, width of acc_i and r_data_o; output format is IEEE-754 single.
- FP_MANT_W, 23, scale mantissa field width (implicit leading 1).
- FP_EXP_W, 8, scale exponent field width.
- FP_EXP_BIAS, 127, exponent bias of the scale and of the output.
- BIT_NUM, 8, operand quantization width; informational only, no effect on arithmetic.

Ports:
- clk  input  1  clock.
- rstnn  input  1  reset; one clock, reset is synchronous and active-high (asserted = 1, sampled on the rising edge of clk).
- acc_i  input  FP_DATA_W  signed two's-complement accumulator.
- mantissa_scale_i  input  FP_MANT_W  scale fraction bits.
- exp_scale_i  input  FP_EXP_W  scale biased exponent; the scale sign is always positive.
- r_data_o  output  FP_DATA_W  IEEE-754 result of acc × scale.

Behaviour:
- Reset: all pipeline registers clear. r_data_o = 0 from the cycle after reset is sampled until new results propagate. Reset mid-stream discards in-flight data.
- Latency: inputs sampled at edge N appear on r_data_o after edge N+2. A new input is accepted every cycle.
- Stage 1 (registered):
  - sign = acc_i[MSB].
  - mag = |acc_i| as a 32-bit unsigned value; -2^31 gives mag = 2^31.
  - sig = {1, mantissa_scale_i}, 24 bits.
  - e = exp_scale_i.
- Stage 2 (registered):
  - P = mag × sig, exact 56-bit product.
  - p = index of the leading one of P.
  - Biased output exponent E = p + e − FP_MANT_W.
  - Fraction = the 23 bits below the leading one, rounded once, round-to-nearest-even, using guard and sticky taken from all lower bits.
  - A rounding carry out of the mantissa increments E and clears the fraction.
- Special cases, evaluated in stage 2 in priority order:
  - e = 255 → 0x7FC00000 (quiet NaN).
  - acc = 0 or e = 0 → +0 (0x00000000). Scale subnormals are flushed.
  - E ≥ 255 after rounding → signed infinity.
  - E ≤ 0 → signed zero. No subnormal outputs; flush-to-zero.
- The output sign is the accumulator sign; a zero result from a nonzero negative acc is −0 (0x80000000).
- No X propagation: every output bit is driven from registers.

Decomposition:
- Shared package holds:
  - FP field widths and bias constants.
  - Special encodings: QNAN 0x7FC00000, +INF 0x7F800000.
  - A leading-one-detect function.
- One sub-module is natural: fp_round_norm, a 56-bit leading-one normalize plus RNE round/pack, used by stage 2.
- The multiplier stays inline.

Test Plan:
- acc=3, exp=127, mant=0 (scale 1.0) → 0x40400000. acc=3, mant=0x400000 (scale 1.5) → 0x40900000 (4.5).
- acc=-5, exp=126, mant=0 (scale 0.5) → 0xC0200000 (−2.5).
- Extremes at scale 1.0:
  - acc=0x7FFFFFFF → 0x4F000000 (rounds up to 2^31).
  - acc=0x80000000 → 0xCF000000.
  - acc=0x01000001 → 0x4B800000 (tie to even).
  - acc=0x01000003 → 0x4B800002.
- Specials:
  - acc=0, any scale → 0x00000000.
  - exp=0 → 0x00000000.
  - exp=255 → 0x7FC00000.
  - acc=0x40000000, exp=254 → 0x7F800000.
  - acc=-0x40000000, exp=254 → 0xFF800000.
- Underflow: acc=1, exp=1, mant=0 → 0x00800000. acc=1, exp=1 followed by acc=-1, exp=1 keeps a normal result. acc=1, exp=0 → 0x00000000.
- Pipeline: drive a new vector every cycle for 20 cycles → each result appears exactly 2 cycles later, in order. Assert rstnn=1 for one cycle mid-stream → r_data_o = 0 on the next two outputs; valid results resume 2 cycles after the first post-reset input.

Source files
------------

// File: rtl/dequantize_elem_pkg.sv
// Shared field widths, special encodings and the leading-one detector used by
// the per-lane dequantizer.
package dequantize_elem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned SIG_W    = MANT_W + 1;
  localparam int unsigned PROD_W   = DATA_W + SIG_W;
  localparam int unsigned LOD_W    = $clog2(PROD_W);

  localparam logic [DATA_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [DATA_W-1:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [DATA_W-1:0] mag;
    logic [SIG_W-1:0]  sig;
    logic [EXP_W-1:0]  exp;
  } stage1_t;

  // Index of the most significant set bit; 0 for an all-zero input.
  function automatic logic [LOD_W-1:0] lod(input logic [PROD_W-1:0] v);
    logic [LOD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(PROD_W); i++) begin
      if (v[i]) idx = LOD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dequantize_elem_round_norm.sv
// Normalizes the exact mag x sig product to its leading one, rounds the
// fraction to nearest-even and packs an IEEE-754 single with inf/zero clamping.
module fp_round_norm
  import dequantize_elem_pkg::*;
(
  input  logic [PROD_W-1:0] prod_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] result_o
);

  logic [LOD_W-1:0]   lead;
  logic [LOD_W-1:0]   shamt;
  logic [PROD_W-2:0]  norm;
  logic [MANT_W-1:0]  frac;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [MANT_W:0]    mant_rnd;
  logic signed [10:0] exp_fin;

  assign lead  = lod(prod_i);
  assign shamt = LOD_W'(PROD_W - 1) - lead;
  // Leading one lands on bit PROD_W-1 and is dropped; fraction sits right below.
  assign norm  = (PROD_W-1)'(prod_i << shamt);

  assign frac     = norm[PROD_W-2 -: MANT_W];
  assign guard    = norm[PROD_W-2-MANT_W];
  assign sticky   = |norm[PROD_W-3-MANT_W:0];
  assign round_up = guard & (sticky | frac[0]);
  assign mant_rnd = {1'b0, frac} + (MANT_W+1)'(round_up);

  assign exp_fin = $signed({5'b0, lead}) + $signed({3'b0, exp_i})
                 - 11'sd23 + $signed({10'b0, mant_rnd[MANT_W]});

  always_comb begin
    result_o = {sign_i, exp_fin[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
    if (exp_fin >= 11'sd255) begin
      result_o = {sign_i, POS_INF[DATA_W-2:0]};
    end else if (exp_fin <= 11'sd0) begin
      result_o = {sign_i, {(DATA_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/dequantize_elem.sv
// One output lane of the dequantize array: signed accumulator times a positive
// FP scale, rounded to IEEE-754 single. Two register stages, one result per clock.
module dequantize_elem
  import dequantize_elem_pkg::*;
#(
  parameter int unsigned FP_DATA_W   = DATA_W,
  parameter int unsigned FP_MANT_W   = MANT_W,
  parameter int unsigned FP_EXP_W    = EXP_W,
  parameter int unsigned FP_EXP_BIAS = EXP_BIAS,
  parameter int unsigned BIT_NUM     = 8
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic [FP_DATA_W-1:0] acc_i,
  input  logic [FP_MANT_W-1:0] mantissa_scale_i,
  input  logic [FP_EXP_W-1:0]  exp_scale_i,
  output logic [FP_DATA_W-1:0] r_data_o
);

  localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = FP_EXP_W'(2 * FP_EXP_BIAS + 1);

  stage1_t           s1_d, s1_q;
  logic [DATA_W-1:0] r_data_d, r_data_q;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] rn_result;

  // -2^31 negates to itself, which read unsigned is exactly 2^31.
  always_comb begin
    s1_d.sign = acc_i[FP_DATA_W-1];
    s1_d.mag  = acc_i[FP_DATA_W-1] ? (~acc_i + 1'b1) : acc_i;
    s1_d.sig  = {1'b1, mantissa_scale_i};
    s1_d.exp  = exp_scale_i;
  end

  assign prod = {{SIG_W{1'b0}}, s1_q.mag} * {{DATA_W{1'b0}}, s1_q.sig};

  fp_round_norm u_round_norm (
    .prod_i   (prod),
    .exp_i    (s1_q.exp),
    .sign_i   (s1_q.sign),
    .result_o (rn_result)
  );

  always_comb begin
    r_data_d = rn_result;
    if (s1_q.exp == EXP_ALL_ONES) begin
      r_data_d = QNAN;
    end else if ((s1_q.mag == '0) || (s1_q.exp == '0)) begin
      r_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstnn) begin
      s1_q     <= '0;
      r_data_q <= '0;
    end else begin
      s1_q     <= s1_d;
      r_data_q <= r_data_d;
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: tb/tb_dequantize_elem.sv
// Self-checking bench for dequantize_elem: directed corner vectors plus random
// streaming traffic checked against an integer-arithmetic reference model.
module tb_dequantize_elem;

  logic        clk;
  logic        rstnn;
  logic [31:0] acc_i;
  logic [22:0] mantissa_scale_i;
  logic [7:0]  exp_scale_i;
  logic [31:0] r_data_o;

  int n_checks = 0;
  int n_errors = 0;

  dequantize_elem dut (
    .clk              (clk),
    .rstnn            (rstnn),
    .acc_i            (acc_i),
    .mantissa_scale_i (mantissa_scale_i),
    .exp_scale_i      (exp_scale_i),
    .r_data_o         (r_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [22:0] mant;
    logic [7:0]  exp;
    logic [31:0] res;
  } vec_t;

  // Exact product, explicit RNE by remainder compare against half an ulp.
  function automatic logic [31:0] ref_deq(input logic [31:0] acc,
                                          input logic [22:0] m,
                                          input logic [7:0]  e);
    longint unsigned mag, prod, q, rem, half;
    int p, sh, ee;
    logic s;
    s   = acc[31];
    mag = s ? (64'd4294967296 - {32'd0, acc}) : {32'd0, acc};
    if (e == 8'd255) return 32'h7FC00000;
    if (mag == 0 || e == 8'd0) return 32'h0;
    prod = mag * (64'd8388608 + {41'd0, m});
    p = 0;
    for (int i = 0; i < 64; i++) if (prod[i]) p = i;
    sh = p - 23;
    if (sh > 0) begin
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = prod << (-sh);
    end
    ee = p + int'(e) - 23;
    if (q == 64'd16777216) begin
      q  = q >> 1;
      ee = ee + 1;
    end
    if (ee >= 255) return {s, 31'h7F800000};
    if (ee <= 0) return {s, 31'd0};
    return {s, 8'(ee), q[22:0]};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [31:0] a;
    a = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) a = -a;
    v.acc  = a;
    v.mant = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       v.exp = 8'd0;
      1:       v.exp = 8'd255;
      2:       v.exp = 8'($urandom_range(1, 3));
      3:       v.exp = 8'($urandom_range(230, 254));
      default: v.exp = 8'($urandom_range(100, 160));
    endcase
    v.res = ref_deq(v.acc, v.mant, v.exp);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    acc_i            = v.acc;
    mantissa_scale_i = v.mant;
    exp_scale_i      = v.exp;
  endtask

  task automatic test_reset();
    rstnn            = 1'b1;
    acc_i            = 32'h1234_5678;
    mantissa_scale_i = 23'h2A_AAAA;
    exp_scale_i      = 8'd130;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (r_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_value: got %h expected %h", r_data_o, 32'h0);
    end
    rstnn = 1'b0;
  endtask

  task automatic test_directed();
    vec_t t[$];
    t.push_back('{32'd3,        23'h000000, 8'd127, 32'h40400000});
    t.push_back('{32'd3,        23'h400000, 8'd127, 32'h40900000});
    t.push_back('{-32'sd5,      23'h000000, 8'd126, 32'hC0200000});
    t.push_back('{32'h7FFFFFFF, 23'h000000, 8'd127, 32'h4F000000});
    t.push_back('{32'h80000000, 23'h000000, 8'd127, 32'hCF000000});
    t.push_back('{32'h01000001, 23'h000000, 8'd127, 32'h4B800000});
    t.push_back('{32'h01000003, 23'h000000, 8'd127, 32'h4B800002});
    t.push_back('{32'h0,        23'h3ABCDE, 8'd140, 32'h00000000});
    t.push_back('{32'd77,       23'h123456, 8'd0,   32'h00000000});
    t.push_back('{32'd77,       23'h123456, 8'd255, 32'h7FC00000});
    t.push_back('{32'h40000000, 23'h000000, 8'd254, 32'h7F800000});
    t.push_back('{-32'sh40000000, 23'h000000, 8'd254, 32'hFF800000});
    t.push_back('{32'd1,        23'h000000, 8'd1,   32'h00800000});
    t.push_back('{32'd1,        23'h000000, 8'd0,   32'h00000000});
    foreach (t[i]) begin
      @(posedge clk);
      #1;
      drive(t[i]);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (r_data_o !== t[i].res) begin
        n_errors++;
        $display("FAIL directed_%0d: acc=%h got %h expected %h",
                 i, t[i].acc, r_data_o, t[i].res);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    a = '{32'd1,  23'h0, 8'd1, 32'h00800000};
    b = '{-32'sd1, 23'h0, 8'd1, 32'h80800000};
    @(posedge clk);
    #1;
    drive(a);
    @(posedge clk);
    #1;
    drive(b);
    @(posedge clk);
    #1;
    n_checks++;
    if (r_data_o !== a.res) begin
      n_errors++;
      $display("FAIL b2b_first: got %h expected %h", r_data_o, a.res);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (r_data_o !== b.res) begin
      n_errors++;
      $display("FAIL b2b_second: got %h expected %h", r_data_o, b.res);
    end
  endtask

  // Streams one vector per cycle; reset_at >= 0 pulses rstnn in that slot.
  task automatic test_stream(input int n, input int reset_at);
    logic [31:0] expq[$];
    vec_t v;
    logic [31:0] e;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk);
      #1;
      rstnn = 1'b0;
      if (i >= 2) begin
        e = expq.pop_front();
        n_checks++;
        if (r_data_o !== e) begin
          n_errors++;
          $display("FAIL stream_slot_%0d: got %h expected %h", i - 2, r_data_o, e);
        end
      end
      if (i < n) begin
        v = rand_vec();
        drive(v);
        if (i == reset_at) begin
          rstnn = 1'b1;
          foreach (expq[k]) expq[k] = 32'h0;
          expq.push_back(32'h0);
        end else begin
          expq.push_back(v.res);
        end
      end
    end
  endtask

  task automatic test_random_single();
    vec_t v;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      v = rand_vec();
      drive(v);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (r_data_o !== v.res) begin
        n_errors++;
        $display("FAIL random_%0d: acc=%h m=%h e=%h got %h expected %h",
                 i, v.acc, v.mant, v.exp, r_data_o, v.res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_single();
    test_stream(20, -1);
    test_stream(40, -1);
    test_stream(16, 7);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
